audio_frame_reader: RTL and testbench



---
 rtl/audio_frm_pkg.sv | 15 +
 rtl/frm_out_stage.sv | 63 ++++++
 rtl/audio_frame_reader.sv | 150 +++++++++++++++
 tb/tb_audio_frame_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_frm_pkg.sv
// rtl/audio_frm_pkg.sv - shared constants and state encoding for the audio frame reader
package audio_frm_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int LEN_W_DEF   = 11;
  localparam int TIMEOUT_DEF = 64;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PAD  = 2'd2
  } frm_state_e;

endpackage

// File: rtl/frm_out_stage.sv
// rtl/frm_out_stage.sv - single-entry output register with load/hold/valid handling
module frm_out_stage
  import audio_frm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_sof,
  input  logic              load_eof,
  input  logic              m_rdy,
  output logic              out_free,
  output logic              m_vld,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;

  assign out_free = !vld_q || m_rdy;

  // Contents only change on a load, so data and markers hold while stalled.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    sof_d  = sof_q;
    eof_d  = eof_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = load_data;
      sof_d  = load_sof;
      eof_d  = load_eof;
    end else if (m_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      sof_q  <= sof_d;
      eof_q  <= eof_d;
    end
  end

  assign m_vld  = vld_q;
  assign m_data = data_q;
  assign m_sof  = sof_q;
  assign m_eof  = eof_q;

endmodule

// File: rtl/audio_frame_reader.sv
// rtl/audio_frame_reader.sv - pops the read-side FIFO and frames samples with sof/eof,
// zero-padding a frame when the FIFO starves mid-frame
module audio_frame_reader
  import audio_frm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic                   cfg_en,
  input  logic [LEN_W-1:0]       cfg_frame_len,
  input  logic                   fifo_rd_vld,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  output logic                   fifo_rd_en,
  output logic                   m_vld,
  input  logic                   m_rdy,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   underrun,
  output logic                   busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  frm_state_e               state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                     underrun_q, underrun_d;

  logic                     out_free;
  logic                     load;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_sof;
  logic                     ld_eof;
  logic [LEN_W-1:0]         len_cfg;

  assign len_cfg = (cfg_frame_len == '0) ? LEN_W'(1) : cfg_frame_len;

  // Gated by reset so a reset cycle never consumes a FIFO entry.
  assign fifo_rd_en = !rd_rst && (state_q == RUN) && fifo_rd_vld && out_free;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    ld_data     = '0;
    ld_sof      = (idx_q == '0);
    ld_eof      = (idx_q == len_q - 1'b1);
    frame_cnt_d = frame_cnt_q;
    if (m_vld && m_rdy && m_eof) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d = RUN;
          len_d   = len_cfg;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      RUN: begin
        if (fifo_rd_en) begin
          load    = 1'b1;
          ld_data = fifo_rd_data;
          timer_d = '0;
          idx_d   = idx_q + 1'b1;
          if (ld_eof) begin
            idx_d = '0;
            if (cfg_en) len_d = len_cfg;
            else        state_d = IDLE;
          end
        end else if ((idx_q != '0) && !fifo_rd_vld) begin
          // Waiting at idx==0 never counts, so gaps between frames are not padded.
          if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_d    = PAD;
            underrun_d = 1'b1;
            timer_d    = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load  = 1'b1;
          idx_d = idx_q + 1'b1;
          if (ld_eof) begin
            idx_d = '0;
            if (cfg_en) begin
              state_d = RUN;
              len_d   = len_cfg;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q     <= IDLE;
      len_q       <= LEN_W'(1);
      idx_q       <= '0;
      timer_q     <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  frm_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .load      (load),
    .load_data (ld_data),
    .load_sof  (ld_sof),
    .load_eof  (ld_eof),
    .m_rdy     (m_rdy),
    .out_free  (out_free),
    .m_vld     (m_vld),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eof     (m_eof)
  );

  assign frame_cnt = frame_cnt_q;
  assign underrun  = underrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_audio_frame_reader.sv
// tb/tb_audio_frame_reader.sv - self-checking bench for audio_frame_reader with a FIFO
// queue model and a frame-level expected-sample scoreboard
module tb_audio_frame_reader;

  localparam int DW = 16;
  localparam int LW = 11;
  localparam int TO = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          cfg_en;
  logic [LW-1:0] cfg_frame_len;
  logic          fifo_rd_vld;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_vld;
  logic          m_rdy;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eof;
  logic [15:0]   frame_cnt;
  logic          underrun;
  logic          busy;

  always #5 rd_clk = ~rd_clk;

  audio_frame_reader #(.DATA_W(DW), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .rd_clk        (rd_clk),
    .rd_rst        (rd_rst),
    .cfg_en        (cfg_en),
    .cfg_frame_len (cfg_frame_len),
    .fifo_rd_vld   (fifo_rd_vld),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .m_vld         (m_vld),
    .m_rdy         (m_rdy),
    .m_data        (m_data),
    .m_sof         (m_sof),
    .m_eof         (m_eof),
    .frame_cnt     (frame_cnt),
    .underrun      (underrun),
    .busy          (busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } smp_t;

  logic [DW-1:0] fifo_q[$];
  smp_t          exp_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   last_pop_cyc = 0;
  int   urun_cyc = 0;
  int   urun_n = 0;
  int   first_acc = -1;
  int   last_acc = -1;
  int   zero_run = 0;
  int   rdy_mode = 0;
  int   vld_mode = 0;
  logic prev_stall = 1'b0;
  smp_t prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then drive fresh inputs just after the rising edge.
  task automatic step();
    smp_t e;
    logic vld_ok;
    @(negedge rd_clk);
    cyc++;
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en) begin
        check("rd_en_out_free", 32'(!m_vld || m_rdy), 32'd1);
        check("rd_en_needs_vld", 32'(fifo_rd_vld), 32'd1);
      end
      if (prev_stall)
        check("stall_hold", 32'({m_vld, m_data, m_sof, m_eof}), 32'({1'b1, prev_out}));
      if (m_vld && m_rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_sample", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("out_sample", 32'({m_data, m_sof, m_eof}), 32'(e));
        end
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      if (fifo_rd_en) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_cnt++;
        last_pop_cyc = cyc;
        zero_run = 0;
      end
      if (underrun) begin
        urun_n++;
        urun_cyc = cyc;
      end
      prev_stall = m_vld && !m_rdy;
      prev_out   = {m_data, m_sof, m_eof};
    end
    @(posedge rd_clk);
    #1;
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = !m_rdy;
      default: m_rdy = ($urandom_range(0, 3) != 0);
    endcase
    vld_ok = (vld_mode == 0) || (zero_run >= 2) || ($urandom_range(0, 2) != 0);
    fifo_rd_vld = (fifo_q.size() > 0) && vld_ok;
    if (!fifo_rd_vld) zero_run++;
    fifo_rd_data = fifo_rd_vld ? fifo_q[0] : DW'($urandom);
  endtask

  task automatic add_samples(input int n, input int len, input int base);
    smp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = (base != 0) ? DW'(base + k) : DW'($urandom);
      e.sof  = ((k % len) == 0);
      e.eof  = ((k % len) == len - 1);
      fifo_q.push_back(e.data);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic s, input logic f);
    smp_t e;
    e.data = d;
    e.sof  = s;
    e.eof  = f;
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_m_vld"},    32'(m_vld), 32'd0);
    check({tag, "_m_data"},   32'(m_data), 32'd0);
    check({tag, "_m_sof"},    32'(m_sof), 32'd0);
    check({tag, "_m_eof"},    32'(m_eof), 32'd0);
    check({tag, "_rd_en"},    32'(fifo_rd_en), 32'd0);
    check({tag, "_frm_cnt"},  32'(frame_cnt), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    cfg_en = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    rdy_mode = 0;
    vld_mode = 0;
    step();
    step();
    check_reset("rst");
    rd_rst = 1'b0;
    first_acc = -1;
    last_acc = -1;
    urun_n = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pops(input string tag, input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      step();
      n++;
    end
    check({tag, "_pops"}, 32'(pop_cnt >= target), 32'd1);
  endtask

  initial begin
    int p0;
    int gap;
    int len;
    int nfr;
    rd_rst = 1'b1;
    cfg_en = 1'b0;
    cfg_frame_len = '0;
    fifo_rd_vld = 1'b0;
    fifo_rd_data = '0;
    m_rdy = 1'b1;

    // Two back-to-back frames of 4 with a continuously ready sink.
    do_reset();
    cfg_frame_len = LW'(4);
    add_samples(8, 4, 1);
    cfg_en = 1'b1;
    drain("t1", 60);
    check("t1_back_to_back", 32'(last_acc - first_acc), 32'd7);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd2);

    // Sink ready toggles every cycle.
    do_reset();
    cfg_frame_len = LW'(4);
    rdy_mode = 1;
    add_samples(12, 4, 0);
    cfg_en = 1'b1;
    drain("t2", 200);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd3);

    // Starvation after 3 samples of an 8-sample frame; data arriving during padding stays queued.
    do_reset();
    cfg_frame_len = LW'(8);
    fifo_q.push_back(16'h0A0A);
    fifo_q.push_back(16'h0B0B);
    fifo_q.push_back(16'h0C0C);
    push_exp(16'h0A0A, 1'b1, 1'b0);
    push_exp(16'h0B0B, 1'b0, 1'b0);
    push_exp(16'h0C0C, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) push_exp('0, 1'b0, (k == 4));
    cfg_en = 1'b1;
    for (int n = 0; n < 60 && urun_n == 0; n++) step();
    check("t3_underrun_seen", 32'(urun_n), 32'd1);
    gap = urun_cyc - last_pop_cyc;
    check("t3_underrun_delay", 32'(gap), 32'(TO + 1));
    cfg_en = 1'b0;
    fifo_q.push_back(16'h0D0D);
    drain("t3", 60);
    step();
    step();
    check("t3_underrun_once", 32'(urun_n), 32'd1);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t3_fifo_left", 32'(fifo_q.size()), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);

    // Enable dropped after the second sample: the frame still completes.
    do_reset();
    cfg_frame_len = LW'(4);
    add_samples(6, 4, 16'h40);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    cfg_en = 1'b1;
    p0 = pop_cnt;
    wait_pops("t4", p0 + 2, 40);
    cfg_en = 1'b0;
    drain("t4", 40);
    step();
    step();
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fifo_left", 32'(fifo_q.size()), 32'd2);
    check("t4_frame_cnt", 32'(frame_cnt), 32'd1);

    // Frame length 0 behaves as 1: every sample is both sof and eof.
    do_reset();
    cfg_frame_len = '0;
    rdy_mode = 2;
    add_samples(5, 1, 0);
    cfg_en = 1'b1;
    drain("t5", 100);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd5);

    // Reset mid-frame at idx 2, then a fresh frame from the next FIFO entry.
    do_reset();
    cfg_frame_len = LW'(4);
    for (int k = 0; k < 6; k++) fifo_q.push_back(DW'(16'h61 + k));
    push_exp(16'h61, 1'b1, 1'b0);
    cfg_en = 1'b1;
    p0 = pop_cnt;
    wait_pops("t6", p0 + 2, 40);
    rd_rst = 1'b1;
    step();
    check_reset("t6_midrst");
    check("t6_fifo_untouched", 32'(fifo_q.size()), 32'd4);
    check("t6_first_acc", 32'(exp_q.size()), 32'd0);
    rd_rst = 1'b0;
    for (int k = 0; k < 4; k++) push_exp(DW'(16'h63 + k), (k == 0), (k == 3));
    drain("t6", 60);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd1);

    // Randomized lengths, sink stalls and FIFO gaps kept shorter than the timeout.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      len = $urandom_range(1, 6);
      nfr = $urandom_range(2, 5);
      cfg_frame_len = LW'(len);
      rdy_mode = 2;
      vld_mode = 1;
      add_samples(len * nfr, len, 0);
      cfg_en = 1'b1;
      drain("t7", 800);
      check("t7_frame_cnt", 32'(frame_cnt), 32'(nfr));
      check("t7_fifo_empty", 32'(fifo_q.size()), 32'd0);
      check("t7_no_underrun", 32'(urun_n), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
